// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style fetch front end: opcodes, reserved words
// and the fetch unit state encoding.
package mips_pkg;

    localparam logic [5:0]  OP_J         = 6'b000010;
    localparam logic [31:0] ILLEGAL_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage : mips_pkg

// File: rtl/instruction_fetch.sv
// Word-addressed instruction fetch stage with in-fetch jump resolution, stall,
// redirect and halt-on-illegal handling, feeding a registered IF/ID boundary.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] ima,
    input  logic [31:0] imrd,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcplus1,
    output logic        if_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  if_instr_d, if_pc_d, if_pcplus1_d, fetch_count_d;
    logic         if_valid_d;
    logic [31:0]  pc_plus1;
    logic         is_jump, is_illegal;

    assign ima        = pc_q;
    assign halted     = (state_q == HALT);
    assign pc_plus1   = pc_q + 32'd1;
    assign is_jump    = (imrd[31:26] == OP_J);
    assign is_illegal = HALT_ON_ILLEGAL && (imrd == ILLEGAL_WORD);

    // NOTE: every output of this block gets a hold default first, so no path
    // through the priority chain can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_instr_d    = if_instr;
        if_pc_d       = if_pc;
        if_pcplus1_d  = if_pcplus1;
        if_valid_d    = if_valid;
        fetch_count_d = fetch_count;

        if (redirect_en) begin
            // Flush: the word at the old PC is discarded, wherever we were.
            state_d    = RUN;
            pc_d       = redirect_pc;
            if_instr_d = 32'h0;
            if_valid_d = 1'b0;
        end else if (state_q == HALT) begin
            if_valid_d = 1'b0;
        end else if (stall) begin
            // Decode is not ready: everything freezes, including halt detection.
        end else if (is_illegal) begin
            state_d    = HALT;
            if_valid_d = 1'b0;
        end else begin
            if_instr_d    = imrd;
            if_pc_d       = pc_q;
            if_pcplus1_d  = pc_plus1;
            if_valid_d    = 1'b1;
            fetch_count_d = fetch_count + 32'd1;
            pc_d          = is_jump ? {pc_plus1[31:26], imrd[25:0]} : pc_plus1;
        end
    end

    // NOTE: state updates use non-blocking assignments so all registers sample
    // the pre-edge values; reset is asynchronous and clears outputs immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            if_instr    <= 32'h0;
            if_pc       <= 32'h0;
            if_pcplus1  <= 32'h0;
            if_valid    <= 1'b0;
            fetch_count <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_instr    <= if_instr_d;
            if_pc       <= if_pc_d;
            if_pcplus1  <= if_pcplus1_d;
            if_valid    <= if_valid_d;
            fetch_count <= fetch_count_d;
        end
    end

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch running the 13-word test program:
// directed stimulus queues expected IF outputs, a negedge monitor checks them.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ima, imrd;
    logic        stall, redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] if_instr, if_pc, if_pcplus1, fetch_count;
    logic        if_valid, halted;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];

    instruction_fetch #(.RESET_PC(32'h0), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ima         (ima),
        .imrd        (imrd),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pcplus1  (if_pcplus1),
        .if_valid    (if_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] addr);
        case (addr)
            32'd0:   rom = 32'h20010001;
            32'd1:   rom = 32'h20020002;
            32'd2:   rom = 32'h00221820;
            32'd3:   rom = 32'h20040004;
            32'd4:   rom = 32'h00832822;
            32'd5:   rom = 32'h20060006;
            32'd6:   rom = 32'h08000002;
            32'd7:   rom = 32'h20070007;
            32'd8:   rom = 32'h00e2202a;
            32'd9:   rom = 32'h2008000a;
            32'd10:  rom = 32'h2009000b;
            32'd11:  rom = 32'h200a000c;
            32'd12:  rom = 32'h200b000d;
            default: rom = 32'hFFFFFFFF;
        endcase
    endfunction

    always_comb imrd = rom(ima);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic cycle(input logic s, input logic r, input logic [31:0] rpc);
        stall       = s;
        redirect_en = r;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    // Expect one accepted instruction at the next edge, then run that edge.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] count);
        exp_q.push_back('{instr: rom(pc), pc: pc, count: count});
        cycle(1'b0, 1'b0, 32'h0);
    endtask

    // Monitor: a new IF register load is signalled by a valid output whose
    // fetch count moved since the previous falling edge.
    logic [31:0] last_count = 32'h0;
    always @(negedge clk) begin
        if (rst_n && if_valid && fetch_count != last_count) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output_pc", if_pc, 32'hDEADBEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_if_instr",   if_instr,    e.instr);
                check("mon_if_pc",      if_pc,       e.pc);
                check("mon_if_pcplus1", if_pcplus1,  e.pc + 32'd1);
                check("mon_count",      fetch_count, e.count);
            end
        end
        last_count = fetch_count;
    end

    initial begin
        static int seq_pc[9]  = '{0, 1, 2, 3, 4, 5, 6, 2, 3};
        static int seq_ima[9] = '{1, 2, 3, 4, 5, 6, 2, 3, 4};

        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        #12 rst_n = 1'b1;
        #1;
        check("rst_ima",      ima,         32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_count",    fetch_count, 32'd0);
        check("rst_halted",   {31'd0, halted},   32'd0);

        // Straight-line fetch through the jump at address 6 back to 2.
        for (int i = 0; i < 9; i++) begin
            fetch(seq_pc[i], i + 1);
            check("run_ima", ima, seq_ima[i]);
            check("run_valid", {31'd0, if_valid}, 32'd1);
        end

        // Three stall cycles at IMA=4.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            check("stall_ima",   ima,         32'd4);
            check("stall_if_pc", if_pc,       32'd3);
            check("stall_count", fetch_count, 32'd9);
        end
        fetch(4, 10);
        check("resume_ima", ima, 32'd5);

        // Redirect to 8 while stalled: redirect wins, one bubble.
        cycle(1'b1, 1'b1, 32'd8);
        check("redir_ima",      ima,         32'd8);
        check("redir_valid",    {31'd0, if_valid}, 32'd0);
        check("redir_if_instr", if_instr,    32'h0);
        check("redir_count",    fetch_count, 32'd10);
        fetch(8, 11);
        check("redir_target_instr", if_instr, 32'h00e2202a);
        check("redir_target_pc",    if_pc,    32'd8);

        // Redirect to 12, fetch it, then halt on the illegal word at 13.
        cycle(1'b0, 1'b1, 32'd12);
        check("r12_ima", ima, 32'd12);
        fetch(12, 12);
        check("r12_next_ima", ima, 32'd13);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            check("halt_halted", {31'd0, halted},   32'd1);
            check("halt_ima",    ima,               32'd13);
            check("halt_valid",  {31'd0, if_valid}, 32'd0);
            check("halt_count",  fetch_count,       32'd12);
        end
        cycle(1'b0, 1'b1, 32'd0);
        check("unhalt_ima",    ima,             32'd0);
        check("unhalt_halted", {31'd0, halted}, 32'd0);
        fetch(0, 13);
        check("unhalt_next_ima", ima, 32'd1);

        // Stall while the illegal word is presented must not halt.
        cycle(1'b0, 1'b1, 32'd13);
        cycle(1'b1, 1'b0, 32'h0);
        check("stall_illegal_halted", {31'd0, halted}, 32'd0);
        check("stall_illegal_ima",    ima,             32'd13);

        // Get back into HALT at 13, then pulse reset between edges.
        cycle(1'b0, 1'b1, 32'd12);
        fetch(12, 14);
        cycle(1'b0, 1'b0, 32'h0);
        check("pre_reset_halted", {31'd0, halted}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_ima",        ima,               32'd0);
        check("async_if_instr",   if_instr,          32'd0);
        check("async_if_pc",      if_pc,             32'd0);
        check("async_if_pcplus1", if_pcplus1,        32'd0);
        check("async_valid",      {31'd0, if_valid}, 32'd0);
        check("async_count",      fetch_count,       32'd0);
        check("async_halted",     {31'd0, halted},   32'd0);
        #4 rst_n = 1'b1;
        fetch(0, 1);
        check("post_reset_ima", ima, 32'd1);

        @(negedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0, word address of the first fetch after reset.
REQ-002 Parameter: HALT_ON_ILLEGAL, 1, when 1 the unit halts on fetching 32'hFFFFFFFF.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  asynchronous active-low reset.
REQ-005 IMA  output  32  word address to instruction memory.
REQ-006 IMRD  input  32  instruction word, combinational from IMA in the same cycle.
REQ-007 STALL  input  1  hold request from decode.
REQ-008 REDIRECT_EN  input  1  branch/flush request from execute.
REQ-009 REDIRECT_PC  input  32  target word address for the redirect.
REQ-010 IF_INSTR  output  32  registered instruction to decode.
REQ-011 IF_PC  output  32  registered word address of IF_INSTR.
REQ-012 IF_PCPLUS1  output  32  registered IF_PC+1.
REQ-013 IF_VALID  output  1  IF_INSTR is a real instruction.
REQ-014 HALTED  output  1  unit is in HALT state.
REQ-015 FETCH_COUNT  output  32  count of instructions accepted into the IF register.

Function
REQ-016 IMA shall equal the PC register combinationally; PC is word-addressed, increment is +1.
REQ-017 States: RUN, HALT; HALTED shall be 1 exactly in HALT.
REQ-018 RUN, STALL=0, REDIRECT_EN=0, legal IMRD: IF_INSTR<=IMRD, IF_PC<=PC, IF_PCPLUS1<=PC+1, IF_VALID<=1, FETCH_COUNT+=1.
REQ-019 Next PC priority: REDIRECT_EN -> REDIRECT_PC; else STALL -> hold; else IMRD[31:26]==6'b000010 -> {PC_plus1[31:26], IMRD[25:0]}; else PC+1.
REQ-020 Jump is resolved in fetch with zero bubbles; the jump word itself is still forwarded with IF_VALID=1.
REQ-021 STALL=1 (no redirect): PC, IF_* registers, FETCH_COUNT and state all hold.
REQ-022 REDIRECT_EN=1: PC<=REDIRECT_PC, IF_VALID<=0, IF_INSTR<=32'h0, FETCH_COUNT holds, state<=RUN; overrides STALL, jump, illegal and HALT.
REQ-023 Illegal word (IMRD==32'hFFFFFFFF, HALT_ON_ILLEGAL=1, STALL=0, no redirect): state<=HALT, PC holds, IF_VALID<=0, count holds.
REQ-024 STALL=1 together with illegal IMRD: no halt; hold per REQ-021.
REQ-025 HALT: PC and IF_* hold with IF_VALID=0; exit only by REDIRECT_EN or reset.
REQ-026 HALT_ON_ILLEGAL=0: 32'hFFFFFFFF is treated as a legal word per REQ-018.
REQ-027 PC+1 and FETCH_COUNT wrap modulo 2^32 (32'hFFFFFFFF -> 0).

Reset
REQ-028 RST_N low shall immediately (asynchronously) set PC=RESET_PC, IF_INSTR=0, IF_PC=0, IF_PCPLUS1=0, IF_VALID=0, FETCH_COUNT=0, state=RUN.
REQ-029 Reset asserted mid-stall, mid-halt or mid-redirect shall behave identically to REQ-028; first fetch at RESET_PC on the first edge after release.

Structure
REQ-030 Shared package mips_pkg shall hold OP_J (6'b000010), ILLEGAL_WORD (32'hFFFFFFFF) and the fetch_state_t enum {RUN, HALT}.
REQ-031 No sub-module; the next-PC mux and the IF register are implemented inline in instruction_fetch.

Verification (bench drives IMRD from the standard 13-word test program: addr 6 = 32'h08000002, addr >=13 = 32'hFFFFFFFF)
REQ-032 Reset release, no stall -> IMA sequence 0,1,2,3,4,5,6,2,3; IF_VALID=1 from cycle 1; IF_PC lags IMA by one cycle.
REQ-033 STALL=1 for 3 cycles while IMA=4 -> IMA stays 4, IF_PC stays 3, FETCH_COUNT frozen; resumes with IMA=5.
REQ-034 REDIRECT_EN=1, REDIRECT_PC=8, with STALL=1 -> next IMA=8, IF_VALID=0 for one cycle, then IF_INSTR=32'h00e2202a, IF_PC=8.
REQ-035 Redirect to 12 -> IMA 12 then 13; IMRD=32'hFFFFFFFF -> HALTED=1, IMA stays 13, IF_VALID=0; a later REDIRECT_PC=0 restarts at IMA=0, HALTED=0.
REQ-036 RST_N pulsed low while HALTED=1 at IMA=13 -> all outputs reset without a clock edge; first post-reset fetch at IMA=0, FETCH_COUNT=1.
